// File: rtl/sde_trigger_arbiter.sv
// sde_trigger_arbiter: merges masked SDE trigger pulses, allocates event buffers
// round-robin, enforces dead time, generates the ENABLE40 phase and counts lost triggers.
module sde_trigger_arbiter #(
    parameter int NUM_SRC   = 6,
    parameter int NUM_BUF   = 4,
    parameter int BUF_WIDTH = 2
) (
    input  logic                 CLK120,
    input  logic                 RST,
    input  logic [NUM_SRC-1:0]   SRC_TRIG,
    input  logic [NUM_SRC-1:0]   SRC_MASK,
    input  logic [15:0]          DEADTIME,
    input  logic                 BUF_RELEASE,
    input  logic [BUF_WIDTH-1:0] BUF_RELEASE_NUM,
    output logic [1:0]           ENABLE40,
    output logic                 TRIG,
    output logic [NUM_SRC-1:0]   TRIG_MASK,
    output logic [BUF_WIDTH-1:0] TRIG_BUF,
    output logic [NUM_BUF-1:0]   BUF_BUSY,
    output logic                 BUFS_FULL,
    output logic [15:0]          LOST_COUNT
);
    typedef enum logic [1:0] {IDLE, FIRE, DEAD} state_t;

    state_t               state_q;
    logic [1:0]           e40_q;
    logic                 trig_q;
    logic [NUM_SRC-1:0]   tmask_q;
    logic [BUF_WIDTH-1:0] tbuf_q;
    logic [BUF_WIDTH-1:0] wr_ptr_q;
    logic [NUM_BUF-1:0]   busy_q;
    logic [NUM_BUF-1:0]   busy_d;
    logic [15:0]          dead_q;
    logic [15:0]          lost_q;
    logic [NUM_SRC-1:0]   hits;
    logic                 hit_idle;
    logic                 accept;
    logic                 lost;
    logic [NUM_BUF-1:0]   rel_oh;
    logic [NUM_BUF-1:0]   alloc_oh;

    assign hits     = SRC_TRIG & SRC_MASK;
    assign hit_idle = (state_q == IDLE) && (|hits);
    // Full check deliberately uses the registered busy bits: a same-cycle release does not rescue.
    assign accept   = hit_idle && !busy_q[wr_ptr_q];
    assign lost     = hit_idle && busy_q[wr_ptr_q];

    always_comb begin
        rel_oh   = '0;
        alloc_oh = '0;
        if (BUF_RELEASE) rel_oh[BUF_RELEASE_NUM] = 1'b1;
        if (accept) alloc_oh[wr_ptr_q] = 1'b1;
        busy_d = (busy_q & ~rel_oh) | alloc_oh;
    end

    always_ff @(posedge CLK120) begin
        if (RST) begin
            state_q  <= IDLE;
            e40_q    <= 2'd0;
            trig_q   <= 1'b0;
            tmask_q  <= '0;
            tbuf_q   <= '0;
            wr_ptr_q <= '0;
            busy_q   <= '0;
            dead_q   <= '0;
            lost_q   <= '0;
        end else begin
            e40_q  <= (e40_q == 2'd2) ? 2'd0 : e40_q + 2'd1;
            busy_q <= busy_d;
            trig_q <= accept;
            if (lost && lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;
            if (accept) begin
                tmask_q  <= hits;
                tbuf_q   <= wr_ptr_q;
                wr_ptr_q <= wr_ptr_q + BUF_WIDTH'(1);
                dead_q   <= DEADTIME;
            end
            case (state_q)
                IDLE: if (accept) state_q <= FIRE;
                FIRE: state_q <= (dead_q != 16'd0) ? DEAD : IDLE;
                DEAD: begin
                    dead_q <= dead_q - 16'd1;
                    if (dead_q == 16'd1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ENABLE40   = e40_q;
    assign TRIG       = trig_q;
    assign TRIG_MASK  = tmask_q;
    assign TRIG_BUF   = tbuf_q;
    assign BUF_BUSY   = busy_q;
    assign BUFS_FULL  = busy_q[wr_ptr_q];
    assign LOST_COUNT = lost_q;
endmodule

// File: tb/tb_sde_trigger_arbiter.sv
// tb_sde_trigger_arbiter: table vectors, directed corner sequences and random stimulus
// checked against a cycle-count based reference model.
module tb_sde_trigger_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  src_trig = '0, src_mask = '0;
    logic [15:0] deadtime = '0;
    logic        rel = 1'b0;
    logic [1:0]  rel_num = '0;
    logic [1:0]  en40;
    logic        trig;
    logic [5:0]  tmask;
    logic [1:0]  tbuf;
    logic [3:0]  busy;
    logic        full;
    logic [15:0] lost;

    int errors = 0;
    int checks = 0;

    int         m_cyc, m_ready, m_wp, m_lost, m_e40;
    logic [3:0] m_busy;
    logic [5:0] m_tmask;
    logic [1:0] m_tbuf;
    logic       m_trig;

    typedef struct {
        logic [5:0]  t, m;
        logic [15:0] d;
        logic        r;
        logic [1:0]  rn;
        logic        e_trig;
        logic [5:0]  e_tmask;
        logic [1:0]  e_tbuf;
        logic [3:0]  e_busy;
        logic [15:0] e_lost;
    } vec_t;
    vec_t tbl[11];

    always #5 clk = ~clk;

    sde_trigger_arbiter #(.NUM_SRC(6), .NUM_BUF(4), .BUF_WIDTH(2)) dut (
        .CLK120(clk), .RST(rst), .SRC_TRIG(src_trig), .SRC_MASK(src_mask),
        .DEADTIME(deadtime), .BUF_RELEASE(rel), .BUF_RELEASE_NUM(rel_num),
        .ENABLE40(en40), .TRIG(trig), .TRIG_MASK(tmask), .TRIG_BUF(tbuf),
        .BUF_BUSY(busy), .BUFS_FULL(full), .LOST_COUNT(lost)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_ready = 0; m_wp = 0; m_lost = 0; m_e40 = 0;
        m_busy = '0; m_tmask = '0; m_tbuf = '0; m_trig = 1'b0;
    endtask

    // The engine is free to sample again at cycle accept+2+deadtime.
    task automatic model_step(input logic [5:0] t, input logic [5:0] m, input logic [15:0] d,
                              input logic r, input logic [1:0] rn);
        logic [5:0] h;
        logic [3:0] alloc;
        h = t & m;
        alloc = '0;
        m_trig = 1'b0;
        if (m_cyc >= m_ready && h != 0) begin
            if (m_busy[m_wp]) begin
                if (m_lost < 65535) m_lost++;
            end else begin
                m_trig = 1'b1;
                m_tmask = h;
                m_tbuf = 2'(m_wp);
                alloc[m_wp] = 1'b1;
                m_wp = (m_wp + 1) % 4;
                m_ready = m_cyc + 2 + int'(d);
            end
        end
        if (r) m_busy[rn] = 1'b0;
        m_busy = m_busy | alloc;
        m_e40 = (m_e40 + 1) % 3;
        m_cyc++;
    endtask

    task automatic check_model();
        chk("enable40", 32'(en40), 32'(m_e40));
        chk("trig", 32'(trig), 32'(m_trig));
        chk("trig_mask", 32'(tmask), 32'(m_tmask));
        chk("trig_buf", 32'(tbuf), 32'(m_tbuf));
        chk("buf_busy", 32'(busy), 32'(m_busy));
        chk("bufs_full", 32'(full), 32'(m_busy[m_wp]));
        chk("lost_count", 32'(lost), 32'(m_lost));
    endtask

    task automatic step(input logic [5:0] t, input logic [5:0] m, input logic [15:0] d,
                        input logic r, input logic [1:0] rn, input bit c);
        src_trig = t; src_mask = m; deadtime = d; rel = r; rel_num = rn;
        model_step(t, m, d, r, rn);
        @(posedge clk);
        #1;
        if (c) check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; src_trig = '0; rel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_model();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{6'h05, 6'h3F, 16'd5, 1'b0, 2'd0, 1'b1, 6'h05, 2'd0, 4'b0001, 16'd0};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{6'h00, 6'h3F, 16'd5, 1'b0, 2'd0, 1'b0, 6'h05, 2'd0, 4'b0001, 16'd0};
        tbl[6]  = '{6'h01, 6'h3F, 16'd5, 1'b0, 2'd0, 1'b0, 6'h05, 2'd0, 4'b0001, 16'd0};
        tbl[7]  = '{6'h02, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1, 6'h02, 2'd1, 4'b0011, 16'd0};
        tbl[8]  = '{6'h00, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b0, 6'h02, 2'd1, 4'b0011, 16'd0};
        tbl[9]  = '{6'h02, 6'h01, 16'd0, 1'b0, 2'd0, 1'b0, 6'h02, 2'd1, 4'b0011, 16'd0};
        tbl[10] = '{6'h00, 6'h3F, 16'd0, 1'b1, 2'd0, 1'b0, 6'h02, 2'd1, 4'b0010, 16'd0};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(6'h00, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
            chk("enable40_seq", 32'(en40), 32'((i + 1) % 3));
        end

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].t, tbl[i].m, tbl[i].d, tbl[i].r, tbl[i].rn, 1'b1);
            chk($sformatf("vec%0d_trig", i), 32'(trig), 32'(tbl[i].e_trig));
            chk($sformatf("vec%0d_mask", i), 32'(tmask), 32'(tbl[i].e_tmask));
            chk($sformatf("vec%0d_buf", i), 32'(tbuf), 32'(tbl[i].e_tbuf));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_lost", i), 32'(lost), 32'(tbl[i].e_lost));
        end

        // Fill every buffer, lose one, then release and reuse.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(6'h01, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
            if (i < 4) chk("full_tbuf", 32'(tbuf), 32'(i));
            step(6'h00, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        end
        chk("full_flag", 32'(full), 32'd1);
        chk("full_lost", 32'(lost), 32'd1);
        step(6'h00, 6'h3F, 16'd0, 1'b1, 2'd0, 1'b1);
        step(6'h01, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        chk("reuse_trig", 32'(trig), 32'd1);
        chk("reuse_tbuf", 32'(tbuf), 32'd0);
        step(6'h00, 6'h3F, 16'd0, 1'b1, 2'd1, 1'b1);
        step(6'h01, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        chk("reuse1_tbuf", 32'(tbuf), 32'd1);
        chk("allbusy", 32'(busy), 32'hF);
        step(6'h00, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        // Release of WR_PTR in the same cycle as a trigger does not save it.
        step(6'h01, 6'h3F, 16'd0, 1'b1, 2'd2, 1'b1);
        chk("same_cyc_trig", 32'(trig), 32'd0);
        chk("same_cyc_lost", 32'(lost), 32'd2);
        chk("same_cyc_busy", 32'(busy), 32'b1011);
        step(6'h01, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        chk("after_same_trig", 32'(trig), 32'd1);
        chk("after_same_tbuf", 32'(tbuf), 32'd2);

        // Reset in the middle of a dead period.
        do_reset();
        step(6'h08, 6'h3F, 16'd10, 1'b0, 2'd0, 1'b1);
        repeat (3) step(6'h00, 6'h3F, 16'd10, 1'b0, 2'd0, 1'b1);
        do_reset();
        step(6'h04, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        chk("post_rst_trig", 32'(trig), 32'd1);
        chk("post_rst_tbuf", 32'(tbuf), 32'd0);

        // DEADTIME changes during DEAD must not alter the current dead period.
        do_reset();
        step(6'h01, 6'h3F, 16'd3, 1'b0, 2'd0, 1'b1);
        step(6'h00, 6'h3F, 16'd40, 1'b0, 2'd0, 1'b1);
        repeat (3) step(6'h00, 6'h3F, 16'd40, 1'b0, 2'd0, 1'b1);
        step(6'h01, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        chk("dead_sampled_once", 32'(trig), 32'd1);

        do_reset();
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00, 6'($urandom),
                 16'($urandom_range(0, 6)), 1'($urandom_range(0, 3) == 0), 2'($urandom), 1'b1);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(6'h01, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
            step(6'h00, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b1);
        end
        for (int i = 0; i < 65537; i++) step(6'h01, 6'h3F, 16'd0, 1'b0, 2'd0, 1'b0);
        check_model();
        chk("lost_saturated", 32'(lost), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
